// File: rtl/ps2_note_pkg.sv
// ps2_note_pkg: scancodes, note codes and receiver state shared by the PS/2 note decoder
package ps2_note_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_A = 8'h1C;
  localparam logic [7:0] SC_B = 8'h32;
  localparam logic [7:0] SC_C = 8'h21;
  localparam logic [7:0] SC_D = 8'h23;
  localparam logic [7:0] SC_E = 8'h24;
  localparam logic [7:0] SC_F = 8'h2B;
  localparam logic [7:0] SC_G = 8'h34;
  localparam logic [2:0] NOTE_OFF = 3'd0;
  localparam logic [2:0] NOTE_A = 3'd1;
  localparam logic [2:0] NOTE_B = 3'd2;
  localparam logic [2:0] NOTE_C = 3'd3;
  localparam logic [2:0] NOTE_D = 3'd4;
  localparam logic [2:0] NOTE_E = 3'd5;
  localparam logic [2:0] NOTE_F = 3'd6;
  localparam logic [2:0] NOTE_G = 3'd7;
  function automatic logic [2:0] key_note(input logic [7:0] sc);
    return sc == SC_A ? NOTE_A :
           sc == SC_B ? NOTE_B :
           sc == SC_C ? NOTE_C :
           sc == SC_D ? NOTE_D :
           sc == SC_E ? NOTE_E :
           sc == SC_F ? NOTE_F :
           sc == SC_G ? NOTE_G : NOTE_OFF;
  endfunction
endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 frame receiver with input sync, clock glitch filter, framing FSM and idle timeout
module ps2_rx
  import ps2_note_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_good,
  output logic       o_bad,
  output logic [7:0] o_byte
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [1:0] r_clk_s, r_dat_s;
  logic r_filt, r_filt_d;
  logic [FW-1:0] r_fcnt;
  rx_state_t r_state, w_state_n;
  logic [7:0] r_shift, w_shift_n;
  logic [2:0] r_bit, w_bit_n;
  logic r_par, w_par_n;
  logic [TW-1:0] r_to, w_to_n;
  logic w_sample, w_d, w_flip, w_timeout;
  assign w_flip = r_clk_s[1] != r_filt && r_fcnt == FW'(FILTER_LEN - 1);
  assign w_sample = r_filt_d & ~r_filt;
  assign w_d = r_dat_s[1];
  assign w_timeout = r_state != IDLE && !w_sample && r_to == TW'(TIMEOUT_CYC - 1);
  assign o_byte = r_shift;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_s <= 2'b11;
      r_dat_s <= 2'b11;
      r_filt <= 1'b1;
      r_filt_d <= 1'b1;
      r_fcnt <= '0;
      r_state <= IDLE;
      r_shift <= '0;
      r_bit <= '0;
      r_par <= 1'b0;
      r_to <= '0;
    end else begin
      r_clk_s <= {r_clk_s[0], i_ps2_clk};
      r_dat_s <= {r_dat_s[0], i_ps2_data};
      r_fcnt <= (r_clk_s[1] == r_filt || w_flip) ? '0 : r_fcnt + 1'b1;
      r_filt <= w_flip ? r_clk_s[1] : r_filt;
      r_filt_d <= r_filt;
      r_state <= w_state_n;
      r_shift <= w_shift_n;
      r_bit <= w_bit_n;
      r_par <= w_par_n;
      r_to <= w_to_n;
    end
  end
  // r_par accumulates data and parity bits; odd parity means it ends at 1
  always_comb begin
    w_state_n = r_state;
    w_shift_n = r_shift;
    w_bit_n = r_bit;
    w_par_n = r_par;
    o_good = 1'b0;
    o_bad = 1'b0;
    w_to_n = (r_state == IDLE || w_sample) ? '0 : r_to + 1'b1;
    if (w_timeout) begin
      w_state_n = IDLE;
      w_to_n = '0;
      o_bad = 1'b1;
    end else if (w_sample) begin
      case (r_state)
        IDLE: begin
          w_state_n = w_d ? IDLE : DATA;
          w_bit_n = '0;
          w_par_n = 1'b0;
        end
        DATA: begin
          w_shift_n = {w_d, r_shift[7:1]};
          w_par_n = r_par ^ w_d;
          w_bit_n = r_bit + 3'd1;
          w_state_n = r_bit == 3'd7 ? PARITY : DATA;
        end
        PARITY: begin
          w_par_n = r_par ^ w_d;
          w_state_n = STOP;
        end
        default: begin
          o_good = w_d & r_par;
          o_bad = ~(w_d & r_par);
          w_state_n = IDLE;
        end
      endcase
    end
  end
endmodule

// File: rtl/ps2_note_decoder.sv
// ps2_note_decoder: turns PS/2 keyboard scancodes into a 3-bit note code for a tone player
module ps2_note_decoder
  import ps2_note_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_CYC = CLK_HZ / 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [2:0] note,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);
  logic w_good, w_bad;
  logic [7:0] w_byte;
  logic [2:0] w_key;
  logic r_brk, r_ext;
  assign w_key = key_note(w_byte);
  ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .i_ps2_clk (ps2_clk),
    .i_ps2_data(ps2_data),
    .o_good    (w_good),
    .o_bad     (w_bad),
    .o_byte    (w_byte)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      note <= NOTE_OFF;
      byte_valid <= 1'b0;
      byte_data <= 8'h00;
      frame_err <= 1'b0;
      r_brk <= 1'b0;
      r_ext <= 1'b0;
    end else begin
      byte_valid <= w_good;
      frame_err <= w_bad;
      if (w_good) begin
        byte_data <= w_byte;
        if (w_byte == SC_BREAK) r_brk <= 1'b1;
        else if (w_byte == SC_EXT) r_ext <= 1'b1;
        else begin
          r_brk <= 1'b0;
          r_ext <= 1'b0;
          // extended keys never touch the note; a break only silences the sounding key
          if (!r_ext) note <= r_brk ? (w_key == note ? NOTE_OFF : note) : (w_key != NOTE_OFF ? w_key : note);
        end
      end
    end
  end
endmodule

// File: tb/tb_ps2_note_decoder.sv
// tb_ps2_note_decoder: randomized PS/2 frames checked against a scancode-level note model
module tb_ps2_note_decoder;
  localparam int CLK_HZ = 200000;
  localparam int FL = 4;
  localparam int T = CLK_HZ / 1000;
  logic clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [2:0] note;
  logic byte_valid, frame_err;
  logic [7:0] byte_data;
  int total = 0, bad = 0, v_cnt = 0, e_cnt = 0;
  logic [2:0] note_at_v;
  logic [2:0] m_note;
  logic m_brk, m_ext;
  logic [7:0] m_data;
  int km [logic [7:0]];
  always #5 clk = ~clk;
  ps2_note_decoder #(.CLK_HZ(CLK_HZ), .FILTER_LEN(FL)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .note(note), .byte_valid(byte_valid), .byte_data(byte_data), .frame_err(frame_err)
  );
  always @(negedge clk) begin
    if (byte_valid) begin
      v_cnt++;
      note_at_v = note;
    end
    if (frame_err) e_cnt++;
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic model_byte(input logic [7:0] b);
    m_data = b;
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (m_ext) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (m_brk) begin
      m_brk = 1'b0;
      if (km.exists(b) && km[b] == int'(m_note)) m_note = 3'd0;
    end else if (km.exists(b)) m_note = 3'(km[b]);
  endtask
  task automatic send_bits(input logic [10:0] bits, input int nbits, input int h);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      tick(h);
      ps2_clk = 1'b0;
      tick(h);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask
  task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic bad_stop, input int h);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ flip_par, b, 1'b0};
    send_bits(bits, 11, h);
    tick(h + 12);
    if (!flip_par && !bad_stop) model_byte(b);
  endtask
  task automatic test_reset;
    m_note = 3'd0; m_brk = 1'b0; m_ext = 1'b0; m_data = 8'h00;
    reset = 1'b1;
    tick(4);
    total++; if (note !== 3'd0) begin bad++; $display("FAIL reset_note got=%0d exp=0", note); end
    total++; if (byte_data !== 8'h00) begin bad++; $display("FAIL reset_byte got=%h exp=00", byte_data); end
    total++; if (byte_valid !== 1'b0 || frame_err !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b exp=00", byte_valid, frame_err); end
    reset = 1'b0;
    tick(20);
    total++; if (v_cnt != 0 || e_cnt != 0) begin bad++; $display("FAIL reset_idle got v=%0d e=%0d exp 0 0", v_cnt, e_cnt); end
  endtask
  task automatic test_basic;
    int v0, e0;
    v0 = v_cnt; e0 = e_cnt;
    send_frame(8'h1C, 1'b0, 1'b0, 12);
    total++; if (v_cnt != v0 + 1) begin bad++; $display("FAIL basic_valid got=%0d exp=%0d", v_cnt - v0, 1); end
    total++; if (byte_data !== 8'h1C) begin bad++; $display("FAIL basic_byte got=%h exp=1c", byte_data); end
    total++; if (note !== 3'd1) begin bad++; $display("FAIL basic_note got=%0d exp=1", note); end
    total++; if (note_at_v !== 3'd1) begin bad++; $display("FAIL basic_note_latency got=%0d exp=1", note_at_v); end
    total++; if (e_cnt != e0) begin bad++; $display("FAIL basic_err got=%0d exp=0", e_cnt - e0); end
  endtask
  task automatic test_last_key;
    logic [7:0] seq [4] = '{8'h24, 8'h34, 8'hF0, 8'h24};
    logic [2:0] exp [4] = '{3'd5, 3'd7, 3'd7, 3'd7};
    for (int i = 0; i < 4; i++) begin
      send_frame(seq[i], 1'b0, 1'b0, 10);
      total++; if (note !== exp[i]) begin bad++; $display("FAIL last_key[%0d] got=%0d exp=%0d", i, note, exp[i]); end
    end
  endtask
  task automatic test_release;
    logic [7:0] seq [3] = '{8'h23, 8'hF0, 8'h23};
    logic [2:0] exp [3] = '{3'd4, 3'd4, 3'd0};
    for (int i = 0; i < 3; i++) begin
      send_frame(seq[i], 1'b0, 1'b0, 10);
      total++; if (note !== exp[i]) begin bad++; $display("FAIL release[%0d] got=%0d exp=%0d", i, note, exp[i]); end
    end
  endtask
  task automatic test_frame_errors;
    int v0, e0;
    send_frame(8'h24, 1'b0, 1'b0, 10);
    v0 = v_cnt; e0 = e_cnt;
    send_frame(8'h21, 1'b1, 1'b0, 10);
    total++; if (e_cnt != e0 + 1) begin bad++; $display("FAIL parity_err got=%0d exp=1", e_cnt - e0); end
    total++; if (v_cnt != v0) begin bad++; $display("FAIL parity_valid got=%0d exp=0", v_cnt - v0); end
    total++; if (note !== 3'd5 || byte_data !== 8'h24) begin bad++; $display("FAIL parity_hold got=%0d/%h exp=5/24", note, byte_data); end
    send_frame(8'h32, 1'b0, 1'b1, 10);
    total++; if (e_cnt != e0 + 2 || v_cnt != v0) begin bad++; $display("FAIL stop_err got e=%0d v=%0d exp 1 0", e_cnt - e0 - 1, v_cnt - v0); end
    total++; if (note !== 3'd5) begin bad++; $display("FAIL stop_hold got=%0d exp=5", note); end
  endtask
  task automatic test_timeout;
    int v0, e0, seen, hits;
    logic [10:0] bits;
    v0 = v_cnt; e0 = e_cnt; seen = -1; hits = 0;
    bits = 11'b000_0001_0100;
    send_bits(bits, 4, 15);
    ps2_data = bits[4];
    tick(15);
    ps2_clk = 1'b0;
    // the last sample is seen by the receiver a few cycles after this edge (sync + filter)
    for (int n = 1; n <= T * 6 / 5; n++) begin
      @(negedge clk);
      if (frame_err) begin
        hits++;
        if (seen < 0) seen = n;
      end
      if (n == 15) ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    total++; if (hits != 1) begin bad++; $display("FAIL timeout_pulses got=%0d exp=1", hits); end
    total++; if (seen < T + 4 || seen > T + FL + 8) begin bad++; $display("FAIL timeout_delay got=%0d exp=%0d..%0d", seen, T + 4, T + FL + 8); end
    total++; if (v_cnt != v0) begin bad++; $display("FAIL timeout_valid got=%0d exp=0", v_cnt - v0); end
    tick(2);
    send_frame(8'h32, 1'b0, 1'b0, 12);
    total++; if (note !== 3'd2 || e_cnt != e0 + 1) begin bad++; $display("FAIL timeout_recover got=%0d e=%0d exp=2 e=1", note, e_cnt - e0); end
  endtask
  task automatic test_glitch;
    int v0, e0;
    v0 = v_cnt; e0 = e_cnt;
    ps2_data = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ps2_clk = 1'b0;
      tick(i < 3 ? 1 : int'($urandom_range(1, FL - 1)));
      ps2_clk = 1'b1;
      tick(10);
    end
    ps2_data = 1'b1;
    tick(5);
    total++; if (v_cnt != v0 || e_cnt != e0) begin bad++; $display("FAIL glitch_quiet got v=%0d e=%0d exp 0 0", v_cnt - v0, e_cnt - e0); end
    send_frame(8'hE0, 1'b0, 1'b0, 10);
    send_frame(8'h1C, 1'b0, 1'b0, 10);
    total++; if (note !== 3'd2) begin bad++; $display("FAIL glitch_ext_note got=%0d exp=2", note); end
    total++; if (byte_data !== 8'h1C || v_cnt != v0 + 2 || e_cnt != e0) begin bad++; $display("FAIL glitch_frames got=%h v=%0d e=%0d exp=1c v=2 e=0", byte_data, v_cnt - v0, e_cnt - e0); end
  endtask
  task automatic test_mid_reset;
    int v0, e0;
    send_frame(8'hF0, 1'b0, 1'b0, 10);
    v0 = v_cnt; e0 = e_cnt;
    send_bits(11'b000_0000_1010, 5, 10);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    m_note = 3'd0; m_brk = 1'b0; m_ext = 1'b0; m_data = 8'h00;
    tick(T + 40);
    total++; if (v_cnt != v0 || e_cnt != e0) begin bad++; $display("FAIL midreset_pulses got v=%0d e=%0d exp 0 0", v_cnt - v0, e_cnt - e0); end
    total++; if (note !== 3'd0 || byte_data !== 8'h00) begin bad++; $display("FAIL midreset_state got=%0d/%h exp=0/00", note, byte_data); end
    send_frame(8'h2B, 1'b0, 1'b0, 10);
    total++; if (note !== 3'd6) begin bad++; $display("FAIL midreset_break_cleared got=%0d exp=6", note); end
  endtask
  task automatic test_random;
    logic [7:0] pool [10] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'hF0, 8'hF0, 8'hE0};
    logic [7:0] b;
    logic perr;
    int v0, e0;
    for (int i = 0; i < 40; i++) begin
      b = $urandom_range(0, 10) == 10 ? 8'($urandom) : pool[$urandom_range(0, 9)];
      perr = $urandom_range(0, 7) == 0;
      v0 = v_cnt; e0 = e_cnt;
      send_frame(b, perr, 1'b0, int'($urandom_range(8, 25)));
      total++; if (note !== m_note) begin bad++; $display("FAIL rand_note[%0d] byte=%h got=%0d exp=%0d", i, b, note, m_note); end
      total++; if (byte_data !== m_data) begin bad++; $display("FAIL rand_byte[%0d] got=%h exp=%h", i, byte_data, m_data); end
      total++; if (v_cnt - v0 != int'(!perr) || e_cnt - e0 != int'(perr)) begin bad++; $display("FAIL rand_pulses[%0d] got v=%0d e=%0d exp v=%0d e=%0d", i, v_cnt - v0, e_cnt - e0, !perr, perr); end
    end
  endtask
  initial begin
    km[8'h1C] = 1; km[8'h32] = 2; km[8'h21] = 3; km[8'h23] = 4;
    km[8'h24] = 5; km[8'h2B] = 6; km[8'h34] = 7;
    test_reset();
    test_basic();
    test_last_key();
    test_release();
    test_frame_errors();
    test_timeout();
    test_glitch();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ps2_note_decoder.md
PS2_NOTE_DECODER -- requirements
Module: ps2_note_decoder

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning system clock frequency.
REQ-002 SHALL have parameter FILTER_LEN, default 8, meaning ps2_clk glitch-filter depth in clk cycles.
REQ-003 SHALL have parameter TIMEOUT_CYC, default CLK_HZ/1000, meaning mid-frame idle limit (1 ms).
REQ-004 SHALL have port clk, input, 1, meaning the one system clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning reset, synchronous and active-high.
REQ-006 SHALL have port ps2_clk, input, 1, meaning raw asynchronous PS/2 keyboard clock.
REQ-007 SHALL have port ps2_data, input, 1, meaning raw asynchronous PS/2 keyboard data.
REQ-008 SHALL have port note, output, 3, meaning note code for the downstream tone player (0 = silent, 1..7 = A..G).
REQ-009 SHALL have port byte_valid, output, 1, meaning one-cycle pulse when a good frame completes.
REQ-010 SHALL have port byte_data, output, 8, meaning last good received byte, held until the next good frame.
REQ-011 SHALL have port frame_err, output, 1, meaning one-cycle pulse on parity, start, stop or timeout error.

Function
REQ-012 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before any use.
REQ-013 Filtered ps2_clk SHALL change only after FILTER_LEN consecutive equal synchronized samples; a falling edge of the filtered clock is the sample event.
REQ-014 Receiver FSM SHALL use states IDLE, DATA, PARITY, STOP; IDLE->DATA on a sample with data=0; a sample with data=1 in IDLE is ignored.
REQ-015 DATA SHALL shift in 8 bits LSB first, then go to PARITY; PARITY checks odd parity over data+parity bit; STOP requires data=1.
REQ-016 On the STOP sample: good frame -> byte_data updated and byte_valid pulsed on the next clk; bad parity or stop=0 -> frame_err pulsed and byte discarded; FSM returns to IDLE in both cases.
REQ-017 Outside IDLE, TIMEOUT_CYC clk cycles without a sample event SHALL pulse frame_err and force IDLE; the timeout counter clears on every sample event.
REQ-018 Byte 0xF0 SHALL set break_pending; byte 0xE0 SHALL set ext_pending; neither changes note.
REQ-019 A byte arriving with ext_pending set SHALL never change note and SHALL clear ext_pending and break_pending.
REQ-020 Make codes SHALL map to note: 0x1C->1 (A), 0x32->2 (B), 0x21->3 (C), 0x23->4 (D), 0x24->5 (E), 0x2B->6 (F), 0x34->7 (G); unmapped make codes leave note unchanged.
REQ-021 A mapped make code SHALL replace note (last key wins); a repeated make of the sounding key leaves note unchanged.
REQ-022 A byte with break_pending set SHALL clear break_pending and set note to 0 only if it maps to the currently sounding note; otherwise note is unchanged.
REQ-023 note SHALL update on the same clk edge that byte_valid asserts (1-cycle latency after STOP sample).
REQ-024 frame_err SHALL NOT clear break_pending, ext_pending or note.

Reset
REQ-025 reset SHALL set note=0, byte_valid=0, byte_data=0x00, frame_err=0, FSM=IDLE, break_pending=0, ext_pending=0, filter and synchronizers to 1 (idle bus), timeout counter=0.
REQ-026 reset asserted mid-frame SHALL abandon the frame with no byte_valid and no frame_err pulse.

Structure
REQ-027 Note codes, scancode constants (0xF0, 0xE0, key make codes) and the receiver state enum SHALL live in a shared package ps2_note_pkg.
REQ-028 The frame receiver (sync, filter, FSM, timeout) SHALL be sub-module ps2_rx; the top holds prefix flags and key mapping.

Verification
REQ-029 Frame 0x1C (good parity) -> byte_valid pulse, byte_data=0x1C, note=1.
REQ-030 Sequence 0x24, 0x34, 0xF0 0x24 -> note 5, then 7, stays 7 after the break of E.
REQ-031 Sequence 0x23, 0xF0 0x23 -> note 4, then 0.
REQ-032 Frame 0x21 with flipped parity bit -> frame_err pulse, no byte_valid, note unchanged.
REQ-033 Start bit plus 4 data bits then bus idle 1.2 ms -> frame_err pulse at 1 ms after the last sample; next good frame 0x32 -> note=2.
REQ-034 1-cycle low glitches on ps2_clk in IDLE -> no sample event; 0xE0 0x1C -> note unchanged.
